// File: rtl/y86_pkg.sv
// Shared Y86 definitions: processor status/instruction encodings and the
// boot-time instruction-memory loader state and status constants.
package y86_pkg;

  // Processor status codes
  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } y86_stat_e;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } y86_icode_e;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Loader defaults and FSM encoding
  localparam int unsigned IMEM_BYTES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } ld_state_e;

  // Loader status word {cpu_hold, load_done, load_err}
  typedef struct packed {
    logic cpu_hold;
    logic load_done;
    logic load_err;
  } ld_status_t;

  localparam ld_status_t LD_STAT_BUSY = '{cpu_hold: 1'b1, load_done: 1'b0, load_err: 1'b0};
  localparam ld_status_t LD_STAT_DONE = '{cpu_hold: 1'b0, load_done: 1'b1, load_err: 1'b0};
  localparam ld_status_t LD_STAT_ERR  = '{cpu_hold: 1'b1, load_done: 1'b0, load_err: 1'b1};

  function automatic logic icode_valid(input logic [3:0] icode);
    return icode <= 4'hB;
  endfunction

  function automatic ld_status_t ld_status(input ld_state_e st);
    case (st)
      S_DONE:  return LD_STAT_DONE;
      S_ERR:   return LD_STAT_ERR;
      default: return LD_STAT_BUSY;
    endcase
  endfunction

  // Transfers are only accepted while a frame is being received.
  function automatic logic ld_accepting(input ld_state_e st);
    return (st == S_LEN_LO) || (st == S_LEN_HI) || (st == S_DATA) || (st == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes it into
// instruction memory one cycle after each payload transfer; stalls via in_ready in DONE/ERR.
module imem_loader
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam logic [16:0] MEM_LEN = 17'(MEM_BYTES);

  ld_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [1:0]        rst_sync_q;
  logic              released;
  logic              xfer;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   cnt_inc;
  ld_status_t        stat;

  // Reset asserts asynchronously but releases the FSM only after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign released = rst_sync_q[1];
  assign in_ready = released && ld_accepting(state_q);
  assign xfer     = in_valid && in_ready;
  assign len_full = {in_byte, len_q[7:0]};
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (released && restart) begin
      state_d = S_LEN_LO;
      len_d   = '0;
      sum_d   = '0;
      cnt_d   = '0;
    end else if (xfer) begin
      case (state_q)
        S_LEN_LO: begin
          len_d[7:0] = in_byte;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = in_byte;
          if ({1'b0, len_full} > MEM_LEN) state_d = S_ERR;
          else if (len_full == 16'd0)     state_d = S_CHECK;
          else                            state_d = S_DATA;
        end
        S_DATA: begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = in_byte;
          sum_d   = sum_q + in_byte;
          cnt_d   = cnt_inc;
          if (16'(cnt_inc) == len_q) state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = (in_byte == sum_q) ? S_DONE : S_ERR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN_LO;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign stat         = ld_status(state_q);
  assign cpu_hold     = stat.cpu_hold;
  assign load_done    = stat.load_done;
  assign load_err     = stat.load_err;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign bytes_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue
// that a negedge monitor drains; status is checked one cycle after each frame.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              restart = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   bytes_loaded;

  int                n_pass = 0;
  int                n_total = 0;
  wr_t               exp_q[$];
  logic [ADDR_W-1:0] wa = '0;

  imem_loader #(.MEM_BYTES(1024), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write monitor: every imem_we cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(w.a));
        chk("wr_data", 32'(imem_wdata), 32'(w.d));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic wdat(input logic [7:0] b);
    exp_q.push_back('{a: wa, d: b});
    wa = wa + 1'b1;
    send(b);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    wa = '0;
  endtask

  task automatic status(input string name, input logic done, input logic err, input logic hold,
                        input logic rdy);
    chk({name, "_done"}, 32'(load_done), 32'(done));
    chk({name, "_err"}, 32'(load_err), 32'(err));
    chk({name, "_hold"}, 32'(cpu_hold), 32'(hold));
    chk({name, "_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic [7:0] b;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cnt", 32'(bytes_loaded), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 4-byte image, checksum 30+F0+0A+00 = 2A
    send(8'h04); send(8'h00);
    wdat(8'h30); wdat(8'hF0); wdat(8'h0A); wdat(8'h00);
    send(8'h2A);
    status("img4", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("img4_cnt", 32'(bytes_loaded), 32'd4);
    drain("img4");

    // Same image with a wrong checksum
    pulse_restart();
    chk("restart_cnt", 32'(bytes_loaded), 32'd0);
    send(8'h04); send(8'h00);
    wdat(8'h30); wdat(8'hF0); wdat(8'h0A); wdat(8'h00);
    send(8'h3A);
    status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("badsum");

    // Empty image, good then bad checksum
    pulse_restart();
    send(8'h00); send(8'h00); send(8'h00);
    status("empty_ok", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_restart();
    send(8'h00); send(8'h00); send(8'h01);
    status("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("empty");

    // Length 1025 overflows; 1024 exactly is accepted
    pulse_restart();
    send(8'h01); send(8'h04);
    status("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovf_cnt", 32'(bytes_loaded), 32'd0);
    pulse_restart();
    send(8'h00); send(8'h04);
    status("len1024", 1'b0, 1'b0, 1'b1, 1'b1);

    // Restart coincident with a payload byte drops it
    pulse_restart();
    send(8'h03); send(8'h00);
    wdat(8'h11); wdat(8'h22);
    restart  = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h33;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    wa = '0;
    chk("rs_coinc_cnt", 32'(bytes_loaded), 32'd0);
    chk("rs_coinc_ready", 32'(in_ready), 32'd1);
    chk("rs_coinc_we", 32'(imem_we), 32'd0);
    send(8'h01); send(8'h00);
    wdat(8'h55);
    send(8'h55);
    status("rs_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("rs_reload");

    // Async reset with a write pending
    pulse_restart();
    send(8'h03); send(8'h00);
    wdat(8'h11);
    send(8'h22);
    chk("pend_we_before", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_hold", 32'(cpu_hold), 32'd1);
    chk("arst_cnt", 32'(bytes_loaded), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wa = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);

    // 256-byte image with random idle gaps and garbage on in_byte while idle
    s = 8'h00;
    send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i * 7 + 3);
      s = s + b;
      repeat ($urandom_range(0, 2)) begin
        in_byte = 8'($urandom());
        @(posedge clk);
        #1;
      end
      wdat(b);
    end
    chk("img256_cnt", 32'(bytes_loaded), 32'd256);
    send(s);
    status("img256", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("img256");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
